// File: rtl/spi_config_reg.sv
// Serial configuration register: shifts in a fixed-length frame MSB-first over SPI mode 0,
// commits it atomically to a shadow register, and shifts the prior configuration out on spi_sdo.
module spi_config_reg #(
    parameter int N_BITS = 1280,
    parameter int CNT_W  = 11
) (
    input  logic              spi_sclk,
    input  logic              reset_b,
    input  logic              spi_cs_b,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic [N_BITS-1:0] cfg_out,
    output logic              cfg_valid,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_BITS);

    logic [N_BITS-1:0] shift_q, shift_d;
    logic [N_BITS-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [N_BITS-1:0] shifted;

    assign shifted = {shift_q[N_BITS-2:0], spi_sdi};

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can leave a signal unassigned and infer a latch.
        shift_d = shift_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (spi_cs_b) begin
            cnt_d   = CNT_ZERO;
            shift_d = cfg_q;
            if (cnt_q != CNT_ZERO && cnt_q < CNT_FULL) begin
                err_d = 1'b1;
            end
        end else if (cnt_q < CNT_LAST) begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
            shift_d = shifted;
            cfg_d   = shifted;
            valid_d = 1'b1;
            err_d   = 1'b0;
            cnt_d   = CNT_FULL;
        end else begin
            // Extra bits past a full frame: counter saturates, data holds.
            err_d = 1'b1;
        end
    end

    // NOTE: the wide shift and shadow registers are reset as well, because outputs must read 0 during reset.
    always_ff @(posedge spi_sclk or negedge reset_b) begin
        if (!reset_b) begin
            shift_q <= '0;
            cfg_q   <= '0;
            cnt_q   <= CNT_ZERO;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so all flops update from pre-edge values.
            shift_q <= shift_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign spi_sdo   = ~spi_cs_b & shift_q[N_BITS-1];
    assign cfg_out   = cfg_q;
    assign cfg_valid = valid_q;
    assign frame_err = err_q;

endmodule

// File: doc/spi_config_reg.md
# spi_config_reg

Serial configuration register for the FRIDA core. It sits directly downstream of the CMOS SPI input pads (sclk, sdi, cs_b, reset_b) and upstream of the 16 ADC instances and the 16:1 comparator mux. It shifts in a fixed-length frame MSB-first and commits it atomically to a parallel shadow register. Each write frame also shifts the previously committed configuration out on spi_sdo for readback.

## Interface
- N_BITS, 1280, configuration frame length in bits
- CNT_W, 11, bit-counter width; must satisfy 2^CNT_W > N_BITS
- spi_sclk  input  1  the only clock; all state updates on its rising edge
- reset_b  input  1  asynchronous, active-low reset
- spi_cs_b  input  1  frame enable, active low; sampled on spi_sclk rising edge
- spi_sdi  input  1  serial data in (MOSI), sampled on spi_sclk rising edge
- spi_sdo  output  1  serial readback (MISO) to the sdo pad
- cfg_out  output  N_BITS  committed configuration; bit N_BITS-1 is the first bit of a frame
- cfg_valid  output  1  high once at least one complete frame has been committed
- frame_err  output  1  sticky framing-error flag

## Operation
- State: shift_reg[N_BITS-1:0], cfg_out shadow, cnt[CNT_W-1:0] (range 0..N_BITS), cfg_valid, frame_err.
- Rising edge with spi_cs_b high (IDLE):
  - cnt <= 0; shift_reg <= cfg_out, preloading readback.
  - If 0 < cnt < N_BITS, the frame was short: frame_err <= 1, cfg_out unchanged.
- Rising edge with spi_cs_b low and cnt < N_BITS-1 (SHIFT):
  - shift_reg <= {shift_reg[N_BITS-2:0], spi_sdi}; cnt <= cnt+1.
- Rising edge with spi_cs_b low and cnt == N_BITS-1 (COMMIT):
  - shift_reg shifts as in SHIFT.
  - cfg_out <= {shift_reg[N_BITS-2:0], spi_sdi}; cfg_valid <= 1; frame_err <= 0; cnt <= N_BITS.
- Rising edge with spi_cs_b low and cnt == N_BITS (OVERFLOW):
  - frame_err <= 1; shift_reg, cfg_out and cnt hold. The counter saturates and never wraps.
- spi_sdo = ~spi_cs_b & shift_reg[N_BITS-1]. It is combinational, with no internal tristate; the pad is always output-enabled.
- frame_err is cleared only by reset_b or by a successful COMMIT.
- Protocol rule for the host: supply at least one spi_sclk rising edge with spi_cs_b high between frames and before the first frame. Without that edge, cnt is not cleared and the readback is not preloaded.
- cfg_out changes only at COMMIT or reset, never bit-by-bit. Downstream logic may treat it as quasi-static.

## Timing
- Reset (reset_b low, asynchronous, takes effect immediately):
  - shift_reg = 0, cfg_out = 0, cnt = 0, cfg_valid = 0, frame_err = 0, spi_sdo = 0.
- Reset asserted mid-frame discards the partial frame; cfg_out returns to 0.
- Release reset_b while spi_sclk is low.
- Commit latency: cfg_out and cfg_valid update on the same rising edge that samples bit N_BITS (the last bit). There is no extra pipeline stage.
- Readback timing (SPI mode 0):
  - After the preload edge and spi_cs_b falling, spi_sdo presents old cfg_out[N_BITS-1].
  - After the k-th shifting edge it presents old cfg_out[N_BITS-1-k].
  - The host samples spi_sdo on each rising edge before the shift.
- spi_cs_b and spi_sdi are sampled synchronously only. They are never used as asynchronous controls.

## Test plan
- Reset, one idle edge, then a full 1280-bit frame with pattern 0xA5 repeated (MSB first) -> cfg_out = {160{8'hA5}}, cfg_valid = 1 on edge 1280, frame_err = 0; spi_sdo reads 1280 zeros.
- Idle edge, then a second frame of all ones -> spi_sdo returns the 0xA5 pattern bit-exact, MSB first; cfg_out becomes all ones on edge 1280, unchanged through edge 1279.
- Frame of 1000 bits, then spi_cs_b high plus one edge -> frame_err = 1; cfg_out still holds the previous value. A following good 1280-bit frame clears frame_err to 0.
- Frame of 1285 bits -> commit on edge 1280; edges 1281-1285 set frame_err = 1; cfg_out equals the first 1280 bits; cnt holds at 1280.
- reset_b pulsed low after bit 600 of a frame -> all outputs 0 immediately. Idle edge plus a full frame then commits normally.
- spi_cs_b high with 50 free-running edges -> no change to cfg_out, cfg_valid or frame_err; spi_sdo = 0 throughout.
